// File: rtl/alu_writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_writeback_stage_pkg
// Brief  : Shared CPU types: ALU opcodes, write-back entry, status flag indices
// Rev    : 1.0  initial release
// ============================================================================
package alu_writeback_stage_pkg;

    localparam int CPU_DATA_WIDTH = 16;
    localparam int CPU_REG_ADDR_W = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_INC = 3'd2,
        OP_DEC = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } enum_alu_opcode_t;

    typedef struct packed {
        logic [CPU_DATA_WIDTH-1:0] data;
        logic [CPU_REG_ADDR_W-1:0] addr;
    } wb_entry_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage
`default_nettype wire

// File: rtl/alu_writeback_stage_wb_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_skid_fifo
// Brief  : 2-entry skid FIFO of write-back entries with synchronous flush
// Rev    : 1.0  initial release
// ============================================================================
module wb_skid_fifo
    import alu_writeback_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      wr_valid,
    output logic      wr_ready,
    input  wb_entry_t wr_entry,
    output logic      rd_valid,
    input  logic      rd_ready,
    output wb_entry_t rd_entry
);

    localparam logic [1:0] c_depth = 2'(DEPTH);

    logic [1:0] r_count;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    wb_entry_t  r_mem [0:1];
    logic       w_push;
    logic       w_pop;

    // Readiness depends only on registered occupancy and flush, never on rd_ready.
    assign wr_ready = (r_count < c_depth) & ~flush;
    assign rd_valid = (r_count != 2'd0) & ~flush;
    assign rd_entry = r_mem[r_rd_ptr];
    assign w_push   = wr_valid & wr_ready;
    assign w_pop    = rd_valid & rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module : alu_writeback_stage
// Brief  : Commits ALU status flags and buffers results toward the register file
// Rev    : 1.0  initial release
// ============================================================================
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int REG_ADDR_W = CPU_REG_ADDR_W,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  enum_alu_opcode_t      alu_opcode,
    input  logic [DATA_WIDTH-1:0] arith_out,
    input  logic [1:0]            arith_flag,
    input  logic                  a_msb,
    input  logic                  b_msb,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [3:0]            flags,
    output logic                  carry_out
);

    logic      w_accept;
    logic      w_n;
    logic [3:0] w_flags_next;
    logic [3:0] r_flags;
    wb_entry_t w_wr_entry;
    wb_entry_t w_rd_entry;

    assign w_accept   = in_valid & in_ready;
    assign w_n        = arith_out[DATA_WIDTH-1];
    assign w_wr_entry = '{data: arith_out, addr: dest_reg};

    always_comb begin
        w_flags_next         = 4'b0000;
        w_flags_next[FLAG_Z] = (arith_out == '0);
        w_flags_next[FLAG_N] = w_n;
        case (alu_opcode)
            OP_ADD: begin
                w_flags_next[FLAG_C] = arith_flag[0];
                w_flags_next[FLAG_V] = (a_msb == b_msb) & (w_n != a_msb);
            end
            OP_SUB: begin
                w_flags_next[FLAG_C] = arith_flag[0];
                w_flags_next[FLAG_V] = (a_msb != b_msb) & (w_n != a_msb);
            end
            OP_INC, OP_DEC, OP_SHL, OP_SHR: w_flags_next[FLAG_C] = arith_flag[0];
            OP_MUL:  w_flags_next[FLAG_C] = |arith_flag;
            default: w_flags_next[FLAG_C] = 1'b0;
        endcase
    end

    // Flags commit at accept time; flush does not roll them back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 4'b0000;
        end else if (w_accept) begin
            r_flags <= w_flags_next;
        end
    end

    assign flags     = r_flags;
    assign carry_out = r_flags[FLAG_C];

    wb_skid_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_entry (w_wr_entry),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_entry (w_rd_entry)
    );

    assign wb_data = w_rd_entry.data;
    assign wb_addr = w_rd_entry.addr;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_writeback_stage
// Brief  : Scoreboard bench for alu_writeback_stage with a queue-based model
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_writeback_stage;
    import alu_writeback_stage_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    enum_alu_opcode_t alu_opcode;
    logic [15:0]      arith_out;
    logic [1:0]       arith_flag;
    logic             a_msb;
    logic             b_msb;
    logic [2:0]       dest_reg;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      wb_data;
    logic [2:0]       wb_addr;
    logic [3:0]       flags;
    logic             carry_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  addr;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] model_flags = 4'b0000;

    always #5 clk = ~clk;

    alu_writeback_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_opcode (alu_opcode),
        .arith_out  (arith_out),
        .arith_flag (arith_flag),
        .a_msb      (a_msb),
        .b_msb      (b_msb),
        .dest_reg   (dest_reg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr),
        .flags      (flags),
        .carry_out  (carry_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Status flags straight from the architectural definitions, returned as {V,N,Z,C}.
    function automatic logic [3:0] ref_flags(input enum_alu_opcode_t op, input logic [15:0] res,
                                             input logic [1:0] af, input logic am, input logic bm);
        logic z, n, c, v;
        z = (res == 16'd0);
        n = (res >= 16'h8000);
        c = 1'b0;
        v = 1'b0;
        if (op == OP_ADD || op == OP_SUB || op == OP_INC || op == OP_DEC || op == OP_SHL || op == OP_SHR)
            c = af[0];
        else if (op == OP_MUL)
            c = (af != 2'b00);
        if (op == OP_ADD) v = (am == bm) && (n != am);
        if (op == OP_SUB) v = (am != bm) && (n != am);
        return {v, n, z, c};
    endfunction

    // Monitor / scoreboard: runs on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_flags = 4'b0000;
        end else begin
            chk("flags", {28'd0, flags}, {28'd0, model_flags});
            chk("carry_out", {31'd0, carry_out}, {31'd0, model_flags[0]});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() < 2) && !flush});
            chk("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0) && !flush});
            if (out_valid && exp_q.size() != 0) begin
                chk("wb_data", {16'd0, wb_data}, {16'd0, exp_q[0].data});
                chk("wb_addr", {29'd0, wb_addr}, {29'd0, exp_q[0].addr});
            end
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back('{data: arith_out, addr: dest_reg});
                model_flags = ref_flags(alu_opcode, arith_out, arith_flag, a_msb, b_msb);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input enum_alu_opcode_t op, input logic [15:0] d, input logic [1:0] af,
                          input logic am, input logic bm, input logic [2:0] rd);
        alu_opcode = op;
        arith_out  = d;
        arith_flag = af;
        a_msb      = am;
        b_msb      = bm;
        dest_reg   = rd;
    endtask

    // Presents one result and returns just after the edge that accepted it.
    task automatic drive_one(input enum_alu_opcode_t op, input logic [15:0] d, input logic [1:0] af,
                             input logic am, input logic bm, input logic [2:0] rd);
        bit done = 0;
        set_in(op, d, af, am, bm, rd);
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    logic [3:0] saved_flags;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_in(OP_ADD, 16'd0, 2'b00, 1'b0, 1'b0, 3'd0);
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
        chk("rst_wb_addr", {29'd0, wb_addr}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // ADD overflow into the sign bit
        out_ready = 1'b1;
        drive_one(OP_ADD, 16'h8000, 2'b00, 1'b0, 1'b0, 3'd5);
        chk("add_flags", {28'd0, flags}, 32'hC);
        chk("add_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_wb_data", {16'd0, wb_data}, 32'h8000);
        chk("add_wb_addr", {29'd0, wb_addr}, 32'd5);
        tick();

        // SUB to zero with carry
        drive_one(OP_SUB, 16'h0000, 2'b01, 1'b1, 1'b1, 3'd2);
        chk("sub_flags", {28'd0, flags}, 32'h3);
        chk("sub_carry_out", {31'd0, carry_out}, 32'd1);
        tick();

        // Backpressure: three back-to-back, only two fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(OP_INC, 16'h1111, 2'b00, 1'b0, 1'b0, 3'd1);
        tick();
        set_in(OP_DEC, 16'h2222, 2'b00, 1'b0, 1'b0, 3'd2);
        tick();
        set_in(OP_SHL, 16'h3333, 2'b01, 1'b0, 1'b0, 3'd3);
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
        chk("bp_head_stable", {16'd0, wb_data}, 32'h1111);
        in_valid = 1'b0;
        tick();
        chk("bp_head_stable2", {16'd0, wb_data}, 32'h1111);
        out_ready = 1'b1;
        tick();
        chk("bp_second", {16'd0, wb_data}, 32'h2222);
        chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Simultaneous accept and emit at count==1
        in_valid = 1'b1;
        set_in(OP_MUL, 16'h0100, 2'b10, 1'b0, 1'b0, 3'd0);
        tick();
        for (int i = 1; i <= 6; i++) begin
            set_in(OP_SHR, 16'(16'h0100 + i), 2'b00, 1'b0, 1'b0, 3'(i));
            tick();
            chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_head", {16'd0, wb_data}, 32'(16'h0100 + i));
        end
        in_valid = 1'b0;
        tick();

        // Flush while holding two entries with a new input pending
        out_ready = 1'b0;
        drive_one(OP_ADD, 16'h0042, 2'b01, 1'b0, 1'b0, 3'd4);
        drive_one(OP_MUL, 16'h0000, 2'b10, 1'b0, 1'b0, 3'd6);
        saved_flags = flags;
        flush    = 1'b1;
        in_valid = 1'b1;
        set_in(OP_DIV, 16'hFFFF, 2'b11, 1'b1, 1'b0, 3'd7);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_flags_kept", {28'd0, flags}, {28'd0, saved_flags});
        tick();
        chk("flush_input_dropped", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-transfer
        drive_one(OP_ADD, 16'h0007, 2'b01, 1'b0, 1'b0, 3'd1);
        drive_one(OP_SUB, 16'hF000, 2'b00, 1'b0, 1'b1, 3'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_flags", {28'd0, flags}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_wb_data", {16'd0, wb_data}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [15:0] d;
            case ($urandom_range(0, 5))
                0: d = 16'h0000;
                1: d = 16'h7FFF;
                2: d = 16'h8000;
                3: d = 16'hFFFF;
                default: d = 16'($urandom);
            endcase
            set_in(enum_alu_opcode_t'(3'($urandom_range(0, 7))), d, 2'($urandom),
                   1'($urandom), 1'($urandom), 3'($urandom));
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("final_drained", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
